// File: rtl/spm_lsu_if.sv
// Request/response port between the MEM stage and the LSU, and the scratchpad bus.
// Each bundle has a master (initiator) and a slave (target) view.
interface spm_lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface spm_bus_if;
    logic [31:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [31:0] spm_wr_data;
    logic [31:0] spm_rd_data;

    modport master (
        output spm_addr, spm_as_, spm_rw, spm_wr_data,
        input  spm_rd_data
    );
    modport slave (
        input  spm_addr, spm_as_, spm_rw, spm_wr_data,
        output spm_rd_data
    );
endinterface

// File: rtl/spm_lsu.sv
// Scratchpad load/store unit: byte/half/word accesses, read-modify-write for sub-word stores.
// Latency: error 1 cycle, load / word store 2 cycles, sub-word store 3 cycles after acceptance.
// Backpressure: one request in flight; req_ready only in IDLE, requests seen while busy are ignored.
module spm_lsu #(
    parameter int unsigned SPM_BYTES = 1024,
    parameter logic        READ      = 1'b1,
    parameter logic        WRITE     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    spm_lsu_req_if.slave  req,
    spm_bus_if.master     spm
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rword_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] req_word_addr, load_val, merged;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        req_err, sub_store;

    assign req_word_addr = {req.req_addr[31:2], 2'b00};
    assign req_err = (req.req_size == 2'd3)
                  || (req.req_size == 2'd1 && req.req_addr[0])
                  || (req.req_size == 2'd2 && req.req_addr[1:0] != 2'b00)
                  || (req_word_addr > 32'(SPM_BYTES - 4));
    assign sub_store = we_q && (size_q != 2'd2);

    // Big-endian lanes: byte offset 0 lives in the top byte of the word.
    always_comb begin
        rd_byte = spm.spm_rd_data[31:24];
        case (addr_q[1:0])
            2'd1:    rd_byte = spm.spm_rd_data[23:16];
            2'd2:    rd_byte = spm.spm_rd_data[15:8];
            2'd3:    rd_byte = spm.spm_rd_data[7:0];
            default: rd_byte = spm.spm_rd_data[31:24];
        endcase
        rd_half = addr_q[1] ? spm.spm_rd_data[15:0] : spm.spm_rd_data[31:16];
        case (size_q)
            2'd0:    load_val = {{24{~uns_q & rd_byte[7]}}, rd_byte};
            2'd1:    load_val = {{16{~uns_q & rd_half[15]}}, rd_half};
            default: load_val = spm.spm_rd_data;
        endcase
    end

    always_comb begin
        merged = rword_q;
        if (size_q == 2'd0) begin
            case (addr_q[1:0])
                2'd0:    merged[31:24] = wdata_q[7:0];
                2'd1:    merged[23:16] = wdata_q[7:0];
                2'd2:    merged[15:8]  = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[15:0] = wdata_q[15:0];
        end else begin
            merged[31:16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rword_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req.req_valid) begin
                    we_q    <= req.req_we;
                    uns_q   <= req.req_unsigned;
                    size_q  <= req.req_size;
                    addr_q  <= req.req_addr;
                    wdata_q <= req.req_wdata;
                    if (req_err) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end
                end
                RD: begin
                    rword_q <= spm.spm_rd_data;
                    if (!we_q) begin
                        rsp_rdata_q <= load_val;
                        rsp_err_q   <= 1'b0;
                    end
                end
                WR: begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Reset gates every strobe combinationally so an interrupted WR cycle never commits.
    always_comb begin
        state_nxt       = state;
        req.req_ready   = 1'b0;
        req.rsp_valid   = 1'b0;
        spm.spm_as_     = 1'b1;
        spm.spm_rw      = READ;
        spm.spm_addr    = '0;
        spm.spm_wr_data = '0;
        case (state)
            IDLE: begin
                if (req.req_valid) begin
                    if (req_err)                                state_nxt = RESP;
                    else if (req.req_we && req.req_size == 2'd2) state_nxt = WR;
                    else                                        state_nxt = RD;
                end
            end
            RD:      state_nxt = we_q ? WR : RESP;
            WR:      state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
        if (!rst) begin
            case (state)
                IDLE: req.req_ready = 1'b1;
                RD: begin
                    spm.spm_as_  = 1'b0;
                    spm.spm_addr = {addr_q[31:2], 2'b00};
                end
                WR: begin
                    spm.spm_as_     = 1'b0;
                    spm.spm_rw      = WRITE;
                    spm.spm_addr    = {addr_q[31:2], 2'b00};
                    spm.spm_wr_data = sub_store ? merged : wdata_q;
                end
                default: req.rsp_valid = 1'b1;
            endcase
        end
    end

    assign req.rsp_rdata = rsp_rdata_q;
    assign req.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_spm_lsu.sv
// Bench for spm_lsu: byte-array scratchpad plus a byte-level reference model of loads/stores.
module tb_spm_lsu;
    localparam int SPM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    spm_lsu_req_if req_bus ();
    spm_bus_if     spm_bus ();

    spm_lsu #(.SPM_BYTES(SPM_BYTES), .READ(1'b1), .WRITE(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .req (req_bus.slave),
        .spm (spm_bus.master)
    );

    // Scratchpad: combinational read, write on posedge, plus a backdoor byte port for preload.
    logic [7:0] mem     [0:SPM_BYTES-1];
    logic [7:0] ref_mem [0:SPM_BYTES-1];
    logic       bd_we = 1'b0;
    logic [9:0] bd_addr = '0;
    logic [7:0] bd_dat = '0;
    logic [9:0] spm_idx;

    assign spm_idx = spm_bus.spm_addr[9:0];
    assign spm_bus.spm_rd_data = {mem[spm_idx], mem[spm_idx + 10'd1], mem[spm_idx + 10'd2], mem[spm_idx + 10'd3]};

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_dat;
        end else if (!spm_bus.spm_as_ && spm_bus.spm_rw == 1'b0) begin
            mem[spm_idx]         <= spm_bus.spm_wr_data[31:24];
            mem[spm_idx + 10'd1] <= spm_bus.spm_wr_data[23:16];
            mem[spm_idx + 10'd2] <= spm_bus.spm_wr_data[15:8];
            mem[spm_idx + 10'd3] <= spm_bus.spm_wr_data[7:0];
        end
    end

    typedef struct {
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] exp;
    } ld_vec_t;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic [31:0] a;
    } err_vec_t;

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
            || ((a / 4) * 4 > 32'(SPM_BYTES - 4));
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        logic [31:0] v;
        int i;
        i = int'(a);
        if (sz == 2'd0) begin
            v = {24'h0, ref_mem[i]};
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = {16'h0, ref_mem[i], ref_mem[i+1]};
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]};
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int i;
        i = int'(a);
        if (sz == 2'd0) begin
            ref_mem[i] = wd[7:0];
        end else if (sz == 2'd1) begin
            ref_mem[i]   = wd[15:8];
            ref_mem[i+1] = wd[7:0];
        end else begin
            ref_mem[i]   = wd[31:24];
            ref_mem[i+1] = wd[23:16];
            ref_mem[i+2] = wd[15:8];
            ref_mem[i+3] = wd[7:0];
        end
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = 10'(a);
        bd_dat  = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // Drives one request and records what the DUT did, cycle k counted from acceptance.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int as_cnt, output int rcyc, output int wcyc,
                         output logic [31:0] saddr, output logic [31:0] wdat);
        bit acc;
        acc = 1'b0;
        lat = -1; rdata = '0; err = 1'b0; as_cnt = 0; rcyc = -1; wcyc = -1; saddr = '0; wdat = '0;
        req_bus.req_valid    = 1'b1;
        req_bus.req_we       = we;
        req_bus.req_size     = sz;
        req_bus.req_unsigned = uns;
        req_bus.req_addr     = a;
        req_bus.req_wdata    = wd;
        for (int i = 0; i < 16 && !acc; i++) begin
            @(negedge clk);
            acc = req_bus.req_ready;
        end
        @(posedge clk);
        #1 req_bus.req_valid = 1'b0;
        if (acc) begin
            for (int k = 1; k <= 8 && lat < 0; k++) begin
                if (k > 1) begin
                    @(posedge clk);
                    #1;
                end
                @(negedge clk);
                if (!spm_bus.spm_as_) begin
                    as_cnt++;
                    saddr = spm_bus.spm_addr;
                    if (spm_bus.spm_rw == 1'b1) begin
                        if (rcyc < 0) rcyc = k;
                    end else begin
                        wcyc = k;
                        wdat = spm_bus.spm_wr_data;
                    end
                end
                if (req_bus.rsp_valid) begin
                    lat   = k;
                    rdata = req_bus.rsp_rdata;
                    err   = req_bus.rsp_err;
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        req_bus.req_valid = 1'b0; req_bus.req_we = 1'b0; req_bus.req_size = 2'd0;
        req_bus.req_unsigned = 1'b0; req_bus.req_addr = '0; req_bus.req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (req_bus.req_ready !== 1'b0 || req_bus.rsp_valid !== 1'b0 || spm_bus.spm_as_ !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_held: ready=%b rsp_valid=%b as_=%b want 0 0 1",
                     req_bus.req_ready, req_bus.rsp_valid, spm_bus.spm_as_);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", req_bus.req_ready);
        end
        vectors++;
        if (req_bus.rsp_valid !== 1'b0 || req_bus.rsp_rdata !== 32'h0 || req_bus.rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rsp: valid=%b rdata=%h err=%b want 0 00000000 0",
                     req_bus.rsp_valid, req_bus.rsp_rdata, req_bus.rsp_err);
        end
        vectors++;
        if (spm_bus.spm_as_ !== 1'b1 || spm_bus.spm_rw !== 1'b1 || spm_bus.spm_addr !== 32'h0
            || spm_bus.spm_wr_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_idle_bus: as_=%b rw=%b addr=%h wr=%h want 1 1 0 0",
                     spm_bus.spm_as_, spm_bus.spm_rw, spm_bus.spm_addr, spm_bus.spm_wr_data);
        end
    endtask

    task automatic test_init_mem();
        logic [7:0] pre [4];
        pre[0] = 8'h80; pre[1] = 8'h7F; pre[2] = 8'h12; pre[3] = 8'h34;
        for (int i = 0; i < SPM_BYTES; i++) begin
            if (i >= 32'h10 && i <= 32'h13) poke(i, pre[i - 32'h10]);
            else                            poke(i, 8'($urandom));
        end
        @(negedge clk);
    endtask

    task automatic test_loads();
        ld_vec_t v [5];
        int lat, as_cnt, rcyc, wcyc;
        logic [31:0] rd, sa, wdat;
        logic err;
        v[0] = '{2'd2, 1'b0, 32'h10, 32'h807F1234};
        v[1] = '{2'd0, 1'b0, 32'h10, 32'hFFFFFF80};
        v[2] = '{2'd0, 1'b1, 32'h10, 32'h00000080};
        v[3] = '{2'd1, 1'b0, 32'h10, 32'hFFFF807F};
        v[4] = '{2'd1, 1'b1, 32'h12, 32'h00001234};
        foreach (v[i]) begin
            issue(1'b0, v[i].sz, v[i].uns, v[i].a, 32'h0, lat, rd, err, as_cnt, rcyc, wcyc, sa, wdat);
            vectors++;
            if (lat !== 2) begin
                miscompares++;
                $display("FAIL load%0d_latency: got %0d want 2", i, lat);
            end
            vectors++;
            if (rd !== v[i].exp || err !== 1'b0) begin
                miscompares++;
                $display("FAIL load%0d_data: got %h err=%b want %h err=0", i, rd, err, v[i].exp);
            end
            vectors++;
            if (as_cnt !== 1 || rcyc !== 1 || sa !== 32'h10) begin
                miscompares++;
                $display("FAIL load%0d_strobe: low_cycles=%0d read_cycle=%0d addr=%h want 1 1 00000010",
                         i, as_cnt, rcyc, sa);
            end
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (req_bus.rsp_rdata !== 32'h00001234 || req_bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_hold: rdata=%h valid=%b want 00001234 0", req_bus.rsp_rdata, req_bus.rsp_valid);
        end
    endtask

    task automatic test_sub_store();
        int lat, as_cnt, rcyc, wcyc;
        logic [31:0] rd, sa, wdat;
        logic err;
        issue(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, lat, rd, err, as_cnt, rcyc, wcyc, sa, wdat);
        model_store(2'd0, 32'h11, 32'h000000AA);
        vectors++;
        if (lat !== 3 || rcyc !== 1 || wcyc !== 2 || as_cnt !== 2) begin
            miscompares++;
            $display("FAIL sb_timing: rsp=%0d read=%0d write=%0d low=%0d want 3 1 2 2", lat, rcyc, wcyc, as_cnt);
        end
        vectors++;
        if (wdat !== 32'h80AA1234 || sa !== 32'h10) begin
            miscompares++;
            $display("FAIL sb_wr_data: got %h @%h want 80AA1234 @00000010", wdat, sa);
        end
        vectors++;
        if (rd !== 32'h0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_rsp: rdata=%h err=%b want 0 0", rd, err);
        end
        vectors++;
        if ({mem[32'h10], mem[32'h11], mem[32'h12], mem[32'h13]} !== 32'h80AA1234) begin
            miscompares++;
            $display("FAIL sb_memory: got %h want 80AA1234",
                     {mem[32'h10], mem[32'h11], mem[32'h12], mem[32'h13]});
        end
    endtask

    task automatic test_errors();
        err_vec_t v [5];
        int lat, as_cnt, rcyc, wcyc;
        logic [31:0] rd, sa, wdat, exp;
        logic err;
        v[0] = '{1'b0, 2'd2, 32'h12};
        v[1] = '{1'b0, 2'd1, 32'h13};
        v[2] = '{1'b0, 2'd3, 32'h20};
        v[3] = '{1'b1, 2'd2, 32'h400};
        v[4] = '{1'b1, 2'd0, 32'h401};
        foreach (v[i]) begin
            issue(v[i].we, v[i].sz, 1'b0, v[i].a, 32'hCAFEF00D, lat, rd, err, as_cnt, rcyc, wcyc, sa, wdat);
            vectors++;
            if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
                miscompares++;
                $display("FAIL err%0d_rsp: rsp=%0d err=%b rdata=%h want 1 1 00000000", i, lat, err, rd);
            end
            vectors++;
            if (as_cnt !== 0) begin
                miscompares++;
                $display("FAIL err%0d_no_strobe: low_cycles=%0d want 0", i, as_cnt);
            end
        end
        exp = model_load(2'd2, 1'b0, 32'h3FC);
        issue(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, lat, rd, err, as_cnt, rcyc, wcyc, sa, wdat);
        vectors++;
        if (lat !== 2 || err !== 1'b0 || rd !== exp || sa !== 32'h3FC) begin
            miscompares++;
            $display("FAIL lw_top_word: rsp=%0d err=%b rdata=%h addr=%h want 2 0 %h 000003FC",
                     lat, err, rd, sa, exp);
        end
    endtask

    task automatic test_reset_mid_write();
        bit acc, saw_rsp;
        logic [7:0] b2, b3;
        acc = 1'b0; saw_rsp = 1'b0;
        b2 = ref_mem[32'h12];
        b3 = ref_mem[32'h13];
        req_bus.req_valid = 1'b1; req_bus.req_we = 1'b1; req_bus.req_size = 2'd1;
        req_bus.req_unsigned = 1'b0; req_bus.req_addr = 32'h12; req_bus.req_wdata = {16'h0, ~b2, ~b3};
        for (int i = 0; i < 16 && !acc; i++) begin
            @(negedge clk);
            acc = req_bus.req_ready;
        end
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL rstwr_accept: ready never seen, want 1");
        end
        @(posedge clk);
        #1 req_bus.req_valid = 1'b0;
        @(negedge clk);
        saw_rsp = saw_rsp | req_bus.rsp_valid;
        vectors++;
        if (spm_bus.spm_as_ !== 1'b0 || spm_bus.spm_rw !== 1'b1) begin
            miscompares++;
            $display("FAIL rstwr_read_cycle: as_=%b rw=%b want 0 1", spm_bus.spm_as_, spm_bus.spm_rw);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (spm_bus.spm_as_ !== 1'b1 || req_bus.req_ready !== 1'b0 || req_bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rstwr_gated: as_=%b ready=%b rsp_valid=%b want 1 0 0",
                     spm_bus.spm_as_, req_bus.req_ready, req_bus.rsp_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        saw_rsp = saw_rsp | req_bus.rsp_valid;
        vectors++;
        if (req_bus.req_ready !== 1'b1 || req_bus.rsp_rdata !== 32'h0 || req_bus.rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rstwr_after: ready=%b rdata=%h err=%b want 1 0 0",
                     req_bus.req_ready, req_bus.rsp_rdata, req_bus.rsp_err);
        end
        repeat (3) begin
            @(negedge clk);
            saw_rsp = saw_rsp | req_bus.rsp_valid;
        end
        vectors++;
        if (saw_rsp) begin
            miscompares++;
            $display("FAIL rstwr_no_rsp: rsp_valid seen=1 want 0");
        end
        vectors++;
        if ({mem[32'h12], mem[32'h13]} !== {b2, b3}) begin
            miscompares++;
            $display("FAIL rstwr_memory: got %h want %h", {mem[32'h12], mem[32'h13]}, {b2, b3});
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic [31:0] exp1;
        acc = 1'b0;
        exp1 = model_load(2'd2, 1'b0, 32'h10);
        req_bus.req_valid = 1'b1; req_bus.req_we = 1'b0; req_bus.req_size = 2'd2;
        req_bus.req_unsigned = 1'b0; req_bus.req_addr = 32'h10; req_bus.req_wdata = 32'h0;
        for (int i = 0; i < 16 && !acc; i++) begin
            @(negedge clk);
            acc = req_bus.req_ready;
        end
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL b2b_accept1: ready never seen, want 1");
        end
        @(posedge clk);
        #1;
        req_bus.req_we = 1'b1; req_bus.req_addr = 32'h14; req_bus.req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        vectors++;
        if (req_bus.req_ready !== 1'b0 || req_bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_rd_busy: ready=%b rsp_valid=%b want 0 0", req_bus.req_ready, req_bus.rsp_valid);
        end
        @(negedge clk);
        vectors++;
        if (req_bus.req_ready !== 1'b0 || req_bus.rsp_valid !== 1'b1 || req_bus.rsp_rdata !== exp1) begin
            miscompares++;
            $display("FAIL b2b_resp1: ready=%b valid=%b rdata=%h want 0 1 %h",
                     req_bus.req_ready, req_bus.rsp_valid, req_bus.rsp_rdata, exp1);
        end
        @(negedge clk);
        vectors++;
        if (req_bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept2: ready=%b want 1", req_bus.req_ready);
        end
        @(posedge clk);
        #1 req_bus.req_valid = 1'b0;
        model_store(2'd2, 32'h14, 32'hDEADBEEF);
        @(negedge clk);
        vectors++;
        if (spm_bus.spm_as_ !== 1'b0 || spm_bus.spm_rw !== 1'b0 || spm_bus.spm_addr !== 32'h14
            || spm_bus.spm_wr_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL b2b_write: as_=%b rw=%b addr=%h wr=%h want 0 0 00000014 DEADBEEF",
                     spm_bus.spm_as_, spm_bus.spm_rw, spm_bus.spm_addr, spm_bus.spm_wr_data);
        end
        @(negedge clk);
        vectors++;
        if (req_bus.rsp_valid !== 1'b1 || req_bus.rsp_err !== 1'b0 || req_bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL b2b_resp2: valid=%b err=%b rdata=%h want 1 0 00000000",
                     req_bus.rsp_valid, req_bus.rsp_err, req_bus.rsp_rdata);
        end
        vectors++;
        if ({mem[32'h14], mem[32'h15], mem[32'h16], mem[32'h17]} !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL b2b_memory: got %h want DEADBEEF",
                     {mem[32'h14], mem[32'h15], mem[32'h16], mem[32'h17]});
        end
    endtask

    task automatic test_random();
        int lat, as_cnt, rcyc, wcyc, exp_lat, exp_as;
        logic [31:0] rd, sa, wdat, a, wd, exp_rd;
        logic err, e, we, uns;
        logic [1:0] sz;
        int r;
        for (int n = 0; n < 300; n++) begin
            we  = 1'($urandom_range(1, 0));
            uns = 1'($urandom_range(1, 0));
            sz  = 2'($urandom_range(3, 0));
            wd  = $urandom;
            r   = $urandom_range(15, 0);
            if (r == 0)      a = $urandom | 32'h400;
            else if (r == 1) a = 32'(SPM_BYTES - 8) + 32'($urandom_range(11, 0));
            else             a = 32'($urandom_range(SPM_BYTES - 1, 0));
            if ($urandom_range(3, 0) != 0) begin
                if (sz == 2'd1)      a[0] = 1'b0;
                else if (sz == 2'd2) a[1:0] = 2'b00;
            end
            e       = model_err(sz, a);
            exp_rd  = (!we && !e) ? model_load(sz, uns, a) : 32'h0;
            exp_lat = e ? 1 : (we && sz != 2'd2) ? 3 : 2;
            exp_as  = e ? 0 : (we && sz != 2'd2) ? 2 : 1;
            issue(we, sz, uns, a, wd, lat, rd, err, as_cnt, rcyc, wcyc, sa, wdat);
            if (we && !e) model_store(sz, a, wd);
            vectors++;
            if (lat !== exp_lat || err !== e || rd !== exp_rd || as_cnt !== exp_as) begin
                miscompares++;
                $display("FAIL rand%0d we=%b sz=%0d uns=%b a=%h: rsp=%0d err=%b rdata=%h low=%0d want %0d %b %h %0d",
                         n, we, sz, uns, a, lat, err, rd, as_cnt, exp_lat, e, exp_rd, exp_as);
            end
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
    endtask

    task automatic test_mem_final();
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int i = 0; i < SPM_BYTES; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL mem_image: %0d bytes differ, first at %0d (got %h want %h)",
                     bad, first, mem[first], ref_mem[first]);
        end
    endtask

    initial begin
        test_reset();
        test_init_mem();
        test_loads();
        test_sub_store();
        test_errors();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        test_mem_final();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spm_lsu.md
Name: spm_lsu

Overview:
- Load/store initiator that drives the MEM-side scratchpad (SPM) port on behalf of the MEM stage.
- Accepts byte, halfword and word load/store requests and issues SPM strobe, read/write and address cycles.
- Performs read-modify-write for sub-word stores, because the SPM always writes 4 bytes.
- Returns sign- or zero-extended load data, and reports misaligned or out-of-range accesses without touching the SPM.

Parameters:
- SPM_BYTES, 1024, SPM size in bytes. Legal aligned base addresses are 0..SPM_BYTES-4.
- READ, 1, encoding of spm_rw for a read.
- WRITE, 0, encoding of spm_rw for a write.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 halfword, 2 word, 3 reserved.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned, out-of-range or reserved-size request.
- spm_addr  out  32  word-aligned SPM address.
- spm_as_  out  1  active-low address strobe.
- spm_rw  out  1  READ/WRITE select.
- spm_wr_data  out  32  SPM write data.
- spm_rd_data  in  32  SPM read data.

Behaviour:
- SPM timing:
  - Read data is combinational: valid in the same cycle spm_as_=0 with spm_rw=READ.
  - A write commits at the posedge ending a cycle with spm_as_=0 and spm_rw=WRITE.
- Byte order is big-endian. Byte lane k = req_addr[1:0] occupies spm word bits [31-8k -: 8].
- spm_addr = {req_addr[31:2], 2'b00}.
- Error check, evaluated on acceptance. rsp_err=1 if any of:
  - req_size==3;
  - halfword with req_addr[0]=1;
  - word with req_addr[1:0]!=0;
  - aligned address > SPM_BYTES-4.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE: req_ready=1. On req_valid, latch request fields, then:
    - error -> RESP;
    - load or sub-word store -> RD;
    - word store -> WR.
  - RD: spm_as_=0, spm_rw=READ. Register spm_rd_data, then:
    - load -> RESP;
    - sub-word store -> WR.
  - WR: spm_as_=0, spm_rw=WRITE.
    - Word store: spm_wr_data = req_wdata.
    - Sub-word store: spm_wr_data = registered read word with only the target lane(s) replaced by req_wdata[7:0] or [15:0]. Halfword lane 0 is [31:16]; lane 2 is [15:0].
    - Next state -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. req_ready=0.
- Latency, with acceptance in cycle N:
  - error: rsp_valid in N+1;
  - load or word store: rsp_valid in N+2;
  - sub-word store: rsp_valid in N+3.
- Throughput: one outstanding request; a new one is accepted no earlier than the cycle after RESP. req_valid held while req_ready=0 is ignored, not queued.
- Load extension:
  - byte: selected lane sign- or zero-extended to 32 bits;
  - halfword: selected 16 bits extended;
  - word: unchanged.
- rsp_rdata and rsp_err are registered and hold until the next RESP. rsp_rdata is 0 for stores and errors.
- Idle SPM outputs: spm_as_=1, spm_rw=READ, spm_addr=0, spm_wr_data=0.
- Reset:
  - While rst=1: spm_as_ forced to 1 combinationally, so a reset during WR never commits a write. req_ready=0, rsp_valid=0.
  - Registered values: state IDLE, rsp_rdata=0, rsp_err=0.
  - An in-flight request is dropped with no response.
  - req_ready=1 in the first cycle after rst deasserts.

Test Plan:
- Preload bytes 0x10..0x13 = 80 7F 12 34. LW 0x10 -> rsp_valid at N+2, rsp_rdata=0x807F1234, rsp_err=0; spm_as_ low only in N+1, spm_addr=0x10.
- Same preload:
  - LB 0x10 -> 0xFFFFFF80;
  - LBU 0x10 -> 0x00000080;
  - LH 0x10 -> 0xFFFF807F;
  - LHU 0x12 -> 0x00001234.
- SB 0x11 with wdata 0x000000AA:
  - N+1: READ at 0x10;
  - N+2: WRITE with spm_wr_data=0x80AA1234;
  - N+3: rsp_valid;
  - memory afterwards reads 80 AA 12 34.
- Error and boundary requests:
  - LW 0x12 -> rsp_err=1 at N+1, spm_as_ never low;
  - LH 0x13 -> err;
  - req_size=3 -> err;
  - LW 0x3FC -> ok;
  - SW 0x400 -> err with memory unchanged.
- SH 0x12 with rst asserted during the WR cycle -> no SPM write, no rsp_valid; req_ready=1 in the cycle after rst drops.
- Back-to-back: hold req_valid across LW 0x10 then SW 0x14 (wdata 0xDEADBEEF) -> req_ready low during RD/RESP; second request accepted the cycle after the first rsp_valid; bytes 0x14..0x17 = DE AD BE EF.
